mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 97 +++++++++
 tb/tb_mul_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential signed multiplier: radix-2 shift-add on operand magnitudes, sign applied at the end.
// Latency: OPW+1 clock edges from the accepting start edge to valid.
// Backpressure: none; start is ignored while busy, and result/valid hold in DONE until the next accepted start.
module mul_seq #(
  parameter int OPW = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               muordi,
  input  logic [OPW-1:0]     opera1,
  input  logic [OPW-1:0]     opera2,
  output logic [2*OPW-1:0]   result,
  output logic               valid,
  output logic               busy
);

  localparam int CW = $clog2(OPW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CW-1:0] LAST = CW'(OPW - 1);

  logic [1:0]       state;
  logic [OPW-1:0]   mcand;
  logic [OPW-1:0]   mplier;
  logic [2*OPW-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic             accept;
  logic [OPW-1:0]   mag1;
  logic [OPW-1:0]   mag2;
  logic [OPW:0]     sum;
  logic [2*OPW-1:0] acc_neg;

  assign accept = start && !muordi && (state == IDLE || state == DONE);

  // Unsigned magnitudes; the most-negative operand maps to 2^(OPW-1) without overflow.
  assign mag1 = opera1[OPW-1] ? (OPW'(0) - opera1) : opera1;
  assign mag2 = opera2[OPW-1] ? (OPW'(0) - opera2) : opera2;

  // Extra top bit holds the carry out of the upper-half add before the shift.
  assign sum = {1'b0, acc[2*OPW-1:OPW]} + {1'b0, (mplier[0] ? mcand : OPW'(0))};

  assign acc_neg = ~acc + {{(2*OPW-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mcand  <= mag1;
            mplier <= mag2;
            neg    <= opera1[OPW-1] ^ opera2[OPW-1];
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            valid  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= {sum, acc[OPW-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          result <= neg ? acc_neg : acc;
          valid  <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: scoreboard of reference signed products, checked when valid rises.
module tb_mul_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic        muordi;
  logic [31:0] opera1;
  logic [31:0] opera2;
  logic [63:0] result;
  logic        valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];
  logic [63:0] last_res;

  mul_seq #(.OPW(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .muordi (muordi),
    .opera1 (opera1),
    .opera2 (opera2),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb2;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    return 64'(sa * sb2);
  endfunction

  // Runs one multiply; optionally fires a second start mid-RUN that must be ignored.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit intrude);
    int n;
    logic [63:0] exp;
    start  = 1'b1;
    muordi = 1'b0;
    opera1 = a;
    opera2 = b;
    sb.push_back(model(a, b));
    tick();
    start = 1'b0;
    chk("accept_busy", {63'd0, busy}, 64'd1);
    chk("accept_valid", {63'd0, valid}, 64'd0);
    chk("accept_hold", result, last_res);
    opera1 = $urandom;
    opera2 = $urandom;
    n = 0;
    while (!valid && n < 100) begin
      start = intrude && (n == 5);
      tick();
      n++;
    end
    start = 1'b0;
    chk("latency", 64'(n), 64'd33);
    exp = sb.pop_front();
    chk("product", result, exp);
    chk("done_busy", {63'd0, busy}, 64'd0);
    last_res = exp;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    muordi   = 1'b0;
    opera1   = '0;
    opera2   = '0;
    last_res = '0;
    repeat (3) tick();
    chk("rst_result", result, 64'd0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);

    // First edge after reset release accepts.
    reset = 1'b0;
    do_mul(32'd7, 32'hFFFF_FFFD, 1'b0);
    chk("7x-3", result, 64'hFFFF_FFFF_FFFF_FFEB);
    repeat (3) tick();
    chk("done_hold_valid", {63'd0, valid}, 64'd1);
    chk("done_hold_result", result, 64'hFFFF_FFFF_FFFF_FFEB);

    do_mul(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("minxmin", result, 64'h4000_0000_0000_0000);
    do_mul(32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    chk("m1xmax", result, 64'hFFFF_FFFF_8000_0001);
    do_mul(32'd0, 32'hFFFF_FFFB, 1'b0);
    chk("0x-5", result, 64'd0);
    // Back-to-back: start right on the edge after valid rose.
    do_mul(32'd5, 32'd6, 1'b0);
    chk("5x6", result, 64'h1E);

    // Ignored start during RUN.
    do_mul(32'd1234, 32'hFFFF_FF00, 1'b1);

    // Reset mid-RUN aborts.
    start  = 1'b1;
    opera1 = 32'd9;
    opera2 = 32'd11;
    sb.push_back(model(32'd9, 32'd11));
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    void'(sb.pop_back());
    last_res = '0;
    chk("abort_valid", {63'd0, valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_result", result, 64'd0);
    tick();
    reset = 1'b0;
    do_mul(32'd3, 32'd4, 1'b0);
    chk("3x4", result, 64'hC);

    // muordi=1 in IDLE is ignored.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    last_res = '0;
    start  = 1'b1;
    muordi = 1'b1;
    opera1 = 32'd77;
    opera2 = 32'd88;
    tick();
    start  = 1'b0;
    muordi = 1'b0;
    repeat (40) tick();
    chk("div_valid", {63'd0, valid}, 64'd0);
    chk("div_busy", {63'd0, busy}, 64'd0);

    // start together with reset resolves to reset.
    reset = 1'b1;
    start = 1'b1;
    tick();
    chk("rst_start_busy", {63'd0, busy}, 64'd0);
    start = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_mul($urandom, $urandom, 1'b0);
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
